// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
// Counter encoding, reset value, default table size and the saturating step.
package bp_pkg;

  localparam int unsigned BP_ENTRIES_DEFAULT = 64;
  localparam int unsigned BP_XLEN_DEFAULT    = 32;

  // 2-bit saturating direction counter; MSB is the taken prediction
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_t;

  localparam bp_cnt_t BP_CNT_RESET = WNT;

  // One saturating step toward taken or not-taken
  function automatic bp_cnt_t bp_cnt_next(input bp_cnt_t cnt, input logic taken);
    bp_cnt_t nxt;
    nxt = cnt;
    case (cnt)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Predictor storage: valid/tag/target/counter per entry.
// Combinational read port for fetch lookup, one synchronous read-modify-write
// training port driven from execute. Async active-low reset clears all entries.
module bp_table
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_ENTRIES_DEFAULT,
  parameter int unsigned IDX     = $clog2(ENTRIES),
  parameter int unsigned TW      = 26,
  parameter int unsigned XLEN    = BP_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IDX-1:0]  i_rd_idx,
  output logic            o_rd_valid,
  output logic [TW-1:0]   o_rd_tag,
  output logic [XLEN-1:0] o_rd_target,
  output bp_cnt_t         o_rd_cnt,
  input  logic            i_wr_en,
  input  logic [IDX-1:0]  i_wr_idx,
  input  logic [TW-1:0]   i_wr_tag,
  input  logic [XLEN-1:0] i_wr_target,
  input  logic            i_wr_taken
);

  logic            r_valid  [ENTRIES];
  logic [TW-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0] r_target [ENTRIES];
  bp_cnt_t         r_cnt    [ENTRIES];

  logic            w_wr_hit;

  // Lookup read port; reflects contents before any same-cycle training write
  always_comb begin
    o_rd_valid  = r_valid[i_rd_idx];
    o_rd_tag    = r_tag[i_rd_idx];
    o_rd_target = r_target[i_rd_idx];
    o_rd_cnt    = r_cnt[i_rd_idx];
  end

  // Whether the resolving branch owns the entry it trains
  always_comb begin
    w_wr_hit = r_valid[i_wr_idx] && (r_tag[i_wr_idx] == i_wr_tag);
  end

  // Training write: step counter on an owned entry, allocate on a taken miss,
  // ignore a not-taken miss so an untrained branch never displaces another
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= BP_CNT_RESET;
      end
    end else if (i_wr_en) begin
      if (w_wr_hit) begin
        r_cnt[i_wr_idx] <= bp_cnt_next(r_cnt[i_wr_idx], i_wr_taken);
        if (i_wr_taken) begin
          r_valid[i_wr_idx]  <= 1'b1;
          r_tag[i_wr_idx]    <= i_wr_tag;
          r_target[i_wr_idx] <= i_wr_target;
        end
      end else if (i_wr_taken) begin
        r_cnt[i_wr_idx]    <= WT;
        r_valid[i_wr_idx]  <= 1'b1;
        r_tag[i_wr_idx]    <= i_wr_tag;
        r_target[i_wr_idx] <= i_wr_target;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the pipelined RV32 core.
// Same-cycle fetch lookup, prediction carried F->D->E, training from execute.
// Optional feature: define BP_GSHARE_EN to XOR a global history into the index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_ENTRIES_DEFAULT,
  parameter int unsigned XLEN    = BP_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            flush_e,
  input  logic            update_e,
  input  logic            taken_e,
  input  logic [XLEN-1:0] target_e,
  output logic            bp_f,
  output logic [XLEN-1:0] bp_target_f,
  output logic            bp_d,
  output logic            bp_e
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam int unsigned TW  = XLEN - IDX - 2;

  logic [IDX-1:0]  w_idx_pc;
  logic [IDX-1:0]  w_idx_f;
  logic [TW-1:0]   w_tag_f;
  logic            w_rd_valid;
  logic [TW-1:0]   w_rd_tag;
  logic [XLEN-1:0] w_rd_target;
  bp_cnt_t         w_rd_cnt;
  logic            w_hit;
  logic            w_unused;

  logic            r_bp_d;
  logic [IDX-1:0]  r_idx_d;
  logic [TW-1:0]   r_tag_d;
  logic            r_bp_e;
  logic [IDX-1:0]  r_idx_e;
  logic [TW-1:0]   r_tag_e;

  // Split fetch PC into table index and tag
  always_comb begin
    w_idx_pc = pc_f[IDX+1:2];
    w_tag_f  = pc_f[XLEN-1:IDX+2];
  end

`ifdef BP_GSHARE_EN
  logic [IDX-1:0] r_ghr;

  // Hash global history into the index; this hashed index is what trains later
  always_comb begin
    w_idx_f = w_idx_pc ^ r_ghr;
  end

  // Shift each resolved direction into the global history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ghr <= '0;
    end else if (update_e) begin
      r_ghr <= {r_ghr[IDX-2:0], taken_e};
    end
  end
`else
  // Index is the word-aligned PC bits only
  always_comb begin
    w_idx_f = w_idx_pc;
  end
`endif

  bp_table #(
    .ENTRIES (ENTRIES),
    .IDX     (IDX),
    .TW      (TW),
    .XLEN    (XLEN)
  ) u_table (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_rd_idx    (w_idx_f),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_target (w_rd_target),
    .o_rd_cnt    (w_rd_cnt),
    .i_wr_en     (update_e),
    .i_wr_idx    (r_idx_e),
    .i_wr_tag    (r_tag_e),
    .i_wr_target (target_e),
    .i_wr_taken  (taken_e)
  );

  // Hit detection and same-cycle prediction; target hidden on a miss
  always_comb begin
    w_hit       = w_rd_valid && (w_rd_tag == w_tag_f);
    bp_f        = w_hit && w_rd_cnt[1];
    bp_target_f = w_hit ? w_rd_target : '0;
  end

  // PC alignment bits and counter LSB play no part in the prediction
  always_comb begin
    w_unused = ^{pc_f[1:0], w_rd_cnt[0]};
  end

  // F->D register: flush beats stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bp_d  <= 1'b0;
      r_idx_d <= '0;
      r_tag_d <= '0;
    end else if (flush_d) begin
      r_bp_d  <= 1'b0;
      r_idx_d <= '0;
      r_tag_d <= '0;
    end else if (!stall_d) begin
      r_bp_d  <= bp_f;
      r_idx_d <= w_idx_f;
      r_tag_d <= w_tag_f;
    end
  end

  // D->E register: the E copy of idx/tag addresses the training write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bp_e  <= 1'b0;
      r_idx_e <= '0;
      r_tag_e <= '0;
    end else if (flush_e) begin
      r_bp_e  <= 1'b0;
      r_idx_e <= '0;
      r_tag_e <= '0;
    end else begin
      r_bp_e  <= r_bp_d;
      r_idx_e <= r_idx_d;
      r_tag_e <= r_tag_d;
    end
  end

  // Registered stage predictions for PC-source selection
  always_comb begin
    bp_d = r_bp_d;
    bp_e = r_bp_e;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the pipelined RV32 core. It looks up the fetch PC in a direct-mapped table of 2-bit saturating counters plus tagged branch targets, and returns a taken prediction and target in the same cycle. It carries the prediction down the F→D→E pipeline as the decode-stage and execute-stage prediction bits consumed by the PC-source selection unit, and it trains the table when a branch or jump resolves in execute.

## Interface
- `ENTRIES`, default 64: number of table entries; power of two, ≥4. `IDX = $clog2(ENTRIES)`.
- `XLEN`, default 32: PC width.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `pc_f`  in  XLEN  fetch-stage PC.
- `stall_d`  in  1  hold the F→D register.
- `flush_d`  in  1  clear the F→D register; overrides `stall_d`.
- `flush_e`  in  1  clear the D→E register.
- `update_e`  in  1  a branch or jump resolved in E this cycle.
- `taken_e`  in  1  resolved direction.
- `target_e`  in  XLEN  resolved target.
- `bp_f`  out  1  fetch prediction, combinational.
- `bp_target_f`  out  XLEN  predicted target. Equals the stored target on a hit, 0 otherwise.
- `bp_d`  out  1  registered prediction for the D-stage instruction.
- `bp_e`  out  1  registered prediction for the E-stage instruction.

## Operation
- Index `idx_f = pc_f[IDX+1:2]`. Tag `tag_f = pc_f[XLEN-1:IDX+2]`.
- Entry fields: `valid`, `tag`, `target`, and `cnt` (2-bit).
- Counter states: SNT=00, WNT=01, WT=10, ST=11.
- Hit: `valid[idx] && tag[idx]==tag_f`.
- `bp_f = hit && cnt[idx][1]`.
- `idx_f` and `tag_f` travel with the instruction through the F→D and D→E registers as `idx_d`/`tag_d` and `idx_e`/`tag_e`.
- Update when `update_e` is 1, at `idx_e`:
  - `cnt` increments if `taken_e`, otherwise decrements, saturating at 11 and 00.
  - If `taken_e`: write `tag_e` and `target_e`, and set `valid`.
  - If the entry's tag mismatched (allocation): `cnt` is set to WT if taken; if not taken, `cnt` and the entry are left untouched.
- F→D register (`bp_d`, `idx_d`, `tag_d`):
  - `flush_d` → cleared to 0.
  - else `stall_d` → hold.
  - else capture the F values.
- D→E register (`bp_e`, `idx_e`, `tag_e`):
  - `flush_e` → cleared to 0.
  - else capture the D values.
- Simultaneous lookup and update of the same entry: `bp_f`/`bp_target_f` show the pre-update contents. Write-after-read; no bypass.
- `update_e` together with `flush_d`/`flush_e`: the update still commits, because the resolving instruction is already in E.
- Reset (async, including mid-operation):
  - every `valid`=0, every `cnt`=WNT(01), every `target`=0, every `tag`=0;
  - `bp_d`, `bp_e`, and the pipelined idx/tag all 0;
  - hence `bp_f`=0 and `bp_target_f`=0.

## Timing
- Lookup latency: 0 cycles; `bp_f`/`bp_target_f` are valid in the same cycle as `pc_f`.
- `bp_d` equals the `bp_f` captured at the previous edge, subject to stall/flush. `bp_e` lags `bp_d` by one edge.
- Update visible to lookups 1 cycle after the `update_e` edge.
- No handshake; the pipeline control inputs are level-sensitive and sampled at each edge.

## Configuration
- `BP_GSHARE_EN` defined:
  - adds an `IDX`-bit global history register `ghr`, reset to 0;
  - lookup index becomes `pc_f[IDX+1:2] ^ ghr`, and this XORed index is what is pipelined to E;
  - on `update_e`, `ghr <= {ghr[IDX-2:0], taken_e}`;
  - tag is unchanged.
- Undefined: no `ghr`; index is the PC bits only.

## Structure
- Package `bp_pkg`:
  - counter enum `bp_cnt_t` (SNT/WNT/WT/ST);
  - `BP_CNT_RESET = WNT`;
  - default `ENTRIES`;
  - function `bp_cnt_next(cnt, taken)` (saturating step).
- One sub-module, `bp_table`:
  - storage arrays, async reset, combinational read port, and one synchronous write port;
  - holds `valid`/`tag`/`target`/`cnt`.
- Top level: index/tag generation, hit logic, pipeline registers, and `ghr`.

## Test plan
- Reset, then `pc_f=0x100` → `bp_f=0`, `bp_target_f=0`. Assert `reset_n` low mid-run after training → same result combinationally, and `bp_d=bp_e=0`.
- Lookup 0x100, advance 2 edges, `update_e=1`, `taken_e=1`, `target_e=0x80` → next cycle `pc_f=0x100` gives `bp_f=1`, `bp_target_f=0x80`.
- From WT, 2 taken updates → ST. Then 1 not-taken → WT, `bp_f=1`. Then another not-taken → WNT, `bp_f=0`, and `bp_target_f` stays 0x80.
- After training 0x100 (ENTRIES=64), `pc_f=0x200` (same index, different tag) → `bp_f=0`. Untrained not-taken update on 0x300 → 0x300 entry stays invalid.
- `bp_f=1` with `stall_d=1` for 2 cycles → `bp_d` holds its old value. `flush_d=1` with `stall_d=1` → `bp_d=0`. `flush_e=1` → `bp_e=0` next edge. `update_e` in the same cycle as the flush still trains.
- With `BP_GSHARE_EN`, 3 taken updates → `ghr=6'b000111`. `pc_f=0x100` then reads index 7, not 0. Without the macro it reads index 0.
